// File: rtl/cnn_frame_loader_if.sv
// Pixel-stream and classification-result handshakes between the frame loader and its neighbours.
interface cnn_frame_loader_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              res_valid;
  logic [3:0]        res_digit;
  logic              res_ready;

  modport slave (
    input  s_valid, s_data, s_last, res_ready,
    output s_ready, res_valid, res_digit
  );

  modport master (
    output s_valid, s_data, s_last, res_ready,
    input  s_ready, res_valid, res_digit
  );
endinterface

// File: rtl/cnn_frame_loader.sv
// Raster pixel feeder for the simpleCNN core: fills the image buffer, runs the core, returns the digit.
// Optional run watchdog and sticky timeout port enabled by defining LOADER_TIMEOUT_EN.
module cnn_frame_loader #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 32
`ifdef LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  cnn_frame_loader_if.slave bus,
  output logic              wr_en,
  output logic [4:0]        wr_row,
  output logic [4:0]        wr_col,
  output logic [DATA_W-1:0] wr_data,
  output logic              cnn_enable,
  input  logic              cnn_done,
  input  logic [3:0]        cnn_result,
  output logic              frame_err
`ifdef LOADER_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  localparam logic [4:0] COL_MAX = 5'(IMG_W - 1);
  localparam logic [4:0] ROW_MAX = 5'(IMG_H - 1);

  typedef enum logic [1:0] {LOAD, RUN, RESULT, FLUSH} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       started;
  logic [4:0] row;
  logic [4:0] col;
  logic [3:0] res_digit_q;
  logic       xfer;
  logic       at_end;
  logic       run_expired;

  // started keeps s_ready low until the first edge after reset is released
  assign bus.s_ready   = started && ((state == LOAD) || (state == FLUSH));
  assign bus.res_valid = (state == RESULT);
  assign bus.res_digit = res_digit_q;
  assign cnn_enable    = (state == RUN);
  assign xfer          = bus.s_valid && bus.s_ready;
  assign at_end        = (row == ROW_MAX) && (col == COL_MAX);

`ifdef LOADER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] run_cnt;

  assign run_expired = (state == RUN) && (run_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      run_cnt <= (state == RUN) ? run_cnt + 1'b1 : '0;
      if (run_expired && !cnn_done) timeout <= 1'b1;
    end
  end
`else
  assign run_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (xfer && at_end) state_nxt = bus.s_last ? RUN : FLUSH;
      FLUSH:   if (xfer && bus.s_last) state_nxt = LOAD;
      RUN:     if (cnn_done || run_expired) state_nxt = RESULT;
      RESULT:  if (bus.res_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Buffer write port, raster counters and framing checks; FLUSH leaves counters at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started     <= 1'b0;
      wr_en       <= 1'b0;
      wr_row      <= '0;
      wr_col      <= '0;
      wr_data     <= '0;
      row         <= '0;
      col         <= '0;
      res_digit_q <= '0;
      frame_err   <= 1'b0;
    end else begin
      started <= 1'b1;
      wr_en   <= 1'b0;
      if ((state == LOAD) && xfer) begin
        wr_en   <= 1'b1;
        wr_row  <= row;
        wr_col  <= col;
        wr_data <= bus.s_data;
        if (at_end || bus.s_last) begin
          row <= '0;
          col <= '0;
        end else if (col == COL_MAX) begin
          col <= '0;
          row <= row + 5'd1;
        end else begin
          col <= col + 5'd1;
        end
        if (at_end != bus.s_last) frame_err <= 1'b1;
      end
      if (state == RUN) begin
        if (cnn_done)         res_digit_q <= cnn_result;
        else if (run_expired) res_digit_q <= 4'hF;
      end
    end
  end

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Scoreboard bench for cnn_frame_loader: writes and results are queued at stimulus time and checked by monitors.
module tb_cnn_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en;
  logic [4:0]  wr_row;
  logic [4:0]  wr_col;
  logic [31:0] wr_data;
  logic        cnn_enable;
  logic        cnn_done = 1'b0;
  logic [3:0]  cnn_result = 4'd0;
  logic        frame_err;
`ifdef LOADER_TIMEOUT_EN
  logic        timeout;
`endif

  int checks = 0;
  int failures = 0;
  logic [41:0] wr_q[$];
  logic [3:0]  res_q[$];

  cnn_frame_loader_if #(.DATA_W(32)) bus ();

  always #5 clk = ~clk;

`ifdef LOADER_TIMEOUT_EN
  cnn_frame_loader #(.IMG_W(28), .IMG_H(28), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .cnn_enable(cnn_enable), .cnn_done(cnn_done), .cnn_result(cnn_result),
    .frame_err(frame_err), .timeout(timeout)
  );
`else
  cnn_frame_loader #(.IMG_W(28), .IMG_H(28), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .cnn_enable(cnn_enable), .cnn_done(cnn_done), .cnn_result(cnn_result),
    .frame_err(frame_err)
  );
`endif

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one pixel, waits (bounded) for acceptance, returns on the negedge after the transfer
  task automatic applyStimulus(input logic [31:0] d, input logic last, input bit exp_wr,
                               input int r, input int c);
    int wait_cnt = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!bus.s_ready && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("s_ready_wait", {63'd0, bus.s_ready}, 64'd1);
    if (exp_wr) wr_q.push_back({5'(r), 5'(c), d});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sendFrame(input int n, input int last_idx, input logic [31:0] off);
    for (int idx = 0; idx < n; idx++) begin
      applyStimulus(off + 32'(idx), idx == last_idx, idx < 784, idx / 28, idx % 28);
      if (idx == 783 && n > 784) begin
        checkOutput("overrun_frame_err", {63'd0, frame_err}, 64'd1);
        checkOutput("overrun_no_enable", {63'd0, cnn_enable}, 64'd0);
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic checkReset();
    checkOutput("rst_s_ready", {63'd0, bus.s_ready}, 64'd0);
    checkOutput("rst_wr_en", {63'd0, wr_en}, 64'd0);
    checkOutput("rst_wr_row", {59'd0, wr_row}, 64'd0);
    checkOutput("rst_wr_col", {59'd0, wr_col}, 64'd0);
    checkOutput("rst_wr_data", {32'd0, wr_data}, 64'd0);
    checkOutput("rst_cnn_enable", {63'd0, cnn_enable}, 64'd0);
    checkOutput("rst_res_valid", {63'd0, bus.res_valid}, 64'd0);
    checkOutput("rst_res_digit", {60'd0, bus.res_digit}, 64'd0);
    checkOutput("rst_frame_err", {63'd0, frame_err}, 64'd0);
`ifdef LOADER_TIMEOUT_EN
    checkOutput("rst_timeout", {63'd0, timeout}, 64'd0);
`endif
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkReset();
    wr_q.delete();
    res_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("s_ready_before_edge", {63'd0, bus.s_ready}, 64'd0);
    @(negedge clk);
    checkOutput("s_ready_after_reset", {63'd0, bus.s_ready}, 64'd1);
  endtask

  // Write monitor
  always begin
    @(negedge clk);
    #1;
    if (rst_n && wr_en) begin
      if (wr_q.size() == 0) begin
        checkOutput("unexpected_write", {63'd0, wr_en}, 64'd0);
      end else begin
        logic [41:0] e;
        e = wr_q.pop_front();
        checkOutput("write", {22'd0, wr_row, wr_col, wr_data}, {22'd0, e});
      end
    end
  end

  // Result monitor
  always begin
    @(negedge clk);
    #1;
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (res_q.size() == 0) begin
        checkOutput("unexpected_result", {63'd0, bus.res_valid}, 64'd0);
      end else begin
        logic [3:0] e;
        e = res_q.pop_front();
        checkOutput("result_digit", {60'd0, bus.res_digit}, {60'd0, e});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.s_last    = 1'b0;
    bus.res_ready = 1'b0;

    // Clean frame, then result with back-pressure
    doReset();
    sendFrame(784, 783, 32'd0);
    checkOutput("enable_after_last", {63'd0, cnn_enable}, 64'd1);
    checkOutput("s_ready_in_run", {63'd0, bus.s_ready}, 64'd0);
    repeat (9) @(negedge clk);
    checkOutput("enable_held", {63'd0, cnn_enable}, 64'd1);
    cnn_done = 1'b1;
    cnn_result = 4'd7;
    res_q.push_back(4'd7);
    @(negedge clk);
    cnn_done = 1'b0;
    checkOutput("enable_dropped", {63'd0, cnn_enable}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("res_valid_held", {63'd0, bus.res_valid}, 64'd1);
      checkOutput("res_digit_held", {60'd0, bus.res_digit}, 64'd7);
      checkOutput("s_ready_in_result", {63'd0, bus.s_ready}, 64'd0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checkOutput("res_valid_cleared", {63'd0, bus.res_valid}, 64'd0);
    checkOutput("s_ready_after_result", {63'd0, bus.s_ready}, 64'd1);

    // Early s_last on pixel 100, then a clean frame with done on the first RUN cycle
    sendFrame(100, 99, 32'h1000_0000);
    checkOutput("early_last_err", {63'd0, frame_err}, 64'd1);
    checkOutput("early_last_no_run", {63'd0, cnn_enable}, 64'd0);
    checkOutput("early_last_ready", {63'd0, bus.s_ready}, 64'd1);
    sendFrame(784, 783, 32'h2000_0000);
    checkOutput("enable_after_err", {63'd0, cnn_enable}, 64'd1);
    cnn_done = 1'b1;
    cnn_result = 4'd3;
    bus.res_ready = 1'b1;
    res_q.push_back(4'd3);
    @(negedge clk);
    cnn_done = 1'b0;
    checkOutput("quick_done_valid", {63'd0, bus.res_valid}, 64'd1);
    checkOutput("quick_done_enable", {63'd0, cnn_enable}, 64'd0);
    @(negedge clk);
    bus.res_ready = 1'b0;
    checkOutput("quick_done_cleared", {63'd0, bus.res_valid}, 64'd0);
    checkOutput("err_sticky", {63'd0, frame_err}, 64'd1);

    // Overrun frame of 790 pixels, s_last only on the last one
    doReset();
    sendFrame(790, 789, 32'h3000_0000);
    checkOutput("flush_done_ready", {63'd0, bus.s_ready}, 64'd1);
    checkOutput("flush_no_enable", {63'd0, cnn_enable}, 64'd0);
    checkOutput("flush_no_result", {63'd0, bus.res_valid}, 64'd0);

    // Reset during LOAD at pixel 400
    sendFrame(400, -1, 32'h4000_0000);
    rst_n = 1'b0;
    #1;
    checkReset();
    wr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during RUN
    sendFrame(784, 783, 32'h5000_0000);
    repeat (3) @(negedge clk);
    checkOutput("run_before_reset", {63'd0, cnn_enable}, 64'd1);
    doReset();

    // Final frame: timeout when built with the watchdog, otherwise a normal result
    sendFrame(784, 783, 32'h6000_0000);
`ifdef LOADER_TIMEOUT_EN
    res_q.push_back(4'hF);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checkOutput("timeout_enable_held", {63'd0, cnn_enable}, 64'd1);
    end
    @(negedge clk);
    checkOutput("timeout_enable_dropped", {63'd0, cnn_enable}, 64'd0);
    checkOutput("timeout_res_valid", {63'd0, bus.res_valid}, 64'd1);
    checkOutput("timeout_res_digit", {60'd0, bus.res_digit}, 64'hF);
    checkOutput("timeout_flag", {63'd0, timeout}, 64'd1);
`else
    repeat (4) @(negedge clk);
    cnn_done = 1'b1;
    cnn_result = 4'd9;
    res_q.push_back(4'd9);
    @(negedge clk);
    cnn_done = 1'b0;
    checkOutput("final_res_valid", {63'd0, bus.res_valid}, 64'd1);
`endif
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checkOutput("final_res_cleared", {63'd0, bus.res_valid}, 64'd0);
    checkOutput("final_frame_err", {63'd0, frame_err}, 64'd0);
    @(negedge clk);
    #2;
    checkOutput("wr_queue_left", 64'(wr_q.size()), 64'd0);
    checkOutput("res_queue_left", 64'(res_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
